// File: rtl/reg_wr_arbiter.sv
// Round-robin write arbiter in front of one shared enabled register.
// A request won in IDLE is written during the following WRITE cycle and acknowledged with a one-cycle pulse.
module reg_wr_arbiter #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 8
) (
    input  logic           clk,
    input  logic           res,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] wdata,
    output logic [N-1:0]   gnt,
    output logic           en,
    output logic [W-1:0]   d,
    output logic [W-1:0]   q,
    output logic [N-1:0]   ack,
    output logic           busy
);

    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;
    localparam logic [PW:0] NP = (PW+1)'(N);
    localparam logic [PW-1:0] LAST = PW'(N - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [PW-1:0] r_ptr, w_ptr_nxt;
    logic [N-1:0]  r_gnt, w_gnt_nxt;
    logic          r_en, w_en_nxt;
    logic [W-1:0]  r_d, w_d_nxt;
    logic [W-1:0]  r_q, w_q_nxt;
    logic [N-1:0]  r_ack, w_ack_nxt;
    logic          r_busy, w_busy_nxt;

    logic          w_found;
    logic [PW-1:0] w_win;
    logic [PW:0]   w_idx;
    logic [W-1:0]  w_wsel;
    logic [N-1:0]  w_onehot;

    // Scan req starting at r_ptr; index wraps by subtraction so non-power-of-2 N works.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int unsigned off = 0; off < N; off++) begin
            w_idx = {1'b0, r_ptr} + (PW+1)'(off);
            if (w_idx >= NP) begin
                w_idx = w_idx - NP;
            end
            if (!w_found && req[w_idx[PW-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_idx[PW-1:0];
            end
        end
    end

    always_comb begin
        w_wsel = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (w_win == PW'(i)) begin
                w_wsel = wdata[i*W +: W];
            end
        end
        w_onehot = {{(N-1){1'b0}}, 1'b1} << w_win;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_gnt_nxt   = r_gnt;
        w_en_nxt    = r_en;
        w_d_nxt     = r_d;
        w_q_nxt     = r_q;
        w_ack_nxt   = '0;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state_nxt = WRITE;
                    w_gnt_nxt   = w_onehot;
                    w_en_nxt    = 1'b1;
                    w_d_nxt     = w_wsel;
                    w_ptr_nxt   = (w_win == LAST) ? '0 : w_win + 1'b1;
                end
            end
            WRITE: begin
                // req/wdata are deliberately ignored here; the write uses the latched d.
                w_state_nxt = IDLE;
                w_q_nxt     = r_d;
                w_ack_nxt   = r_gnt;
                w_gnt_nxt   = '0;
                w_en_nxt    = 1'b0;
            end
            default: begin
                w_state_nxt = IDLE;
                w_gnt_nxt   = '0;
                w_en_nxt    = 1'b0;
            end
        endcase
        w_busy_nxt = (w_state_nxt == WRITE);
    end

    always_ff @(posedge clk) begin
        if (!res) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_gnt   <= '0;
            r_en    <= 1'b0;
            r_d     <= '0;
            r_q     <= '0;
            r_ack   <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_gnt   <= w_gnt_nxt;
            r_en    <= w_en_nxt;
            r_d     <= w_d_nxt;
            r_q     <= w_q_nxt;
            r_ack   <= w_ack_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    assign gnt  = r_gnt;
    assign en   = r_en;
    assign d    = r_d;
    assign q    = r_q;
    assign ack  = r_ack;
    assign busy = r_busy;

endmodule

// File: doc/reg_wr_arbiter.md
REG_WR_ARBITER -- requirements
Module: reg_wr_arbiter

Interface
REQ-001 Parameter: N, default 4, number of requesters (2..8).
REQ-002 Parameter: W, default 8, data width of the shared register.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 res  input  1  reset; synchronous, active-low (res=0 at a rising edge resets the block).
REQ-005 req  input  N  per-requester write request; bit i belongs to requester i.
REQ-006 wdata  input  N*W  per-requester write data; requester i occupies bits [i*W +: W].
REQ-007 gnt  output  N  one-hot grant; bit i high for the WRITE cycle of requester i.
REQ-008 en  output  1  write enable to the shared register; high only in the WRITE state.
REQ-009 d  output  W  registered data presented to the shared register; equals the granted requester's wdata.
REQ-010 q  output  W  contents of the shared enabled register held inside the block.
REQ-011 ack  output  N  one-hot, one-cycle pulse; bit i marks completion of requester i's write.
REQ-012 busy  output  1  high whenever the state is not IDLE.

Function
REQ-013 Two states SHALL exist: IDLE and WRITE; there SHALL be no other reachable state.
REQ-014 In IDLE with req==0, state, gnt, en, d and q SHALL hold; ack SHALL be 0.
REQ-015 In IDLE with req!=0 at edge k, the arbiter SHALL select winner w by round-robin from pointer ptr: the first set req bit at index ptr, ptr+1, ... modulo N.
REQ-016 At edge k, the block SHALL register gnt=onehot(w), en=1, d=wdata[w], ptr=(w+1) mod N, and enter WRITE.
REQ-017 At edge k+1 (in WRITE), q SHALL load d, ack SHALL pulse onehot(w) for exactly one cycle, gnt and en SHALL clear, and state SHALL return to IDLE.
REQ-018 Latency SHALL be fixed: req sampled at edge k -> q updated and ack visible after edge k+1; peak throughput one write per two cycles.
REQ-019 req and wdata SHALL be ignored in WRITE; changes in WRITE do not alter d or the winner.
REQ-020 A requester still asserting req in the IDLE cycle after its ack SHALL be treated as a new request and arbitrated normally; it is not favoured because ptr has moved past it.
REQ-021 Round-robin SHALL guarantee that a continuously asserted request is granted within N arbitrations.
REQ-022 ptr SHALL wrap from N-1 to 0; a winner at index N-1 sets ptr=0.
REQ-023 gnt and ack SHALL never have more than one bit set; gnt and ack SHALL never be nonzero in the same cycle.
REQ-024 q SHALL change only on the edge that leaves WRITE, and only to the latched d.
REQ-025 busy SHALL equal (state==WRITE) and be driven from a register.

Reset
REQ-026 res=0 at any edge SHALL force state=IDLE, ptr=0, gnt=0, en=0, d=0, ack=0, q=0, busy=0, overriding all other inputs.
REQ-027 res=0 at the edge that would complete a WRITE SHALL abort it: q=0 and no ack for the pending requester.
REQ-028 The first arbitration after res returns to 1 SHALL start from ptr=0.

Verification
REQ-029 Reset: res=0 for 2 edges with req=4'b1111 -> q=0, gnt=0, en=0, ack=0, busy=0 throughout.
REQ-030 Single write: N=4, W=8, req=4'b0100, wdata[2]=8'hA5 at edge k -> gnt=4'b0100, en=1, d=8'hA5 after k; q=8'hA5, ack=4'b0100 after k+1; idle after k+2.
REQ-031 Fairness: req=4'b1111 held, distinct data per requester -> ack order 0,1,2,3,0 at edges k+1, k+3, k+5, k+7, k+9; q follows each requester's data.
REQ-032 Wrap: ptr=3 (after granting requester 2), req=4'b1001 -> requester 3 granted first, then requester 0; ptr=1 afterward.
REQ-033 Mid-write change: winner 1 granted with wdata[1]=8'h3C, wdata[1] changed to 8'hFF during WRITE -> q=8'h3C.
REQ-034 Reset mid-write: res=0 at the edge ending WRITE for requester 2 -> q=0, ack stays 0, next grant with req=4'b0100 goes to requester 2 with ptr=0 scan.
